// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// IMEM_LOADER_CSUM_EN adds the trailing checksum state.
package imem_loader_pkg;

  localparam int unsigned LEN_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;

`ifdef IMEM_LOADER_CSUM_EN
  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_FLUSH,
    S_CSUM,
    S_RUN,
    S_ERROR
  } loader_state_t;
`else
  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_FLUSH,
    S_RUN,
    S_ERROR
  } loader_state_t;
`endif

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = host/memory side, slave = loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader_byte_word_asm.sv
// Assembles little-endian bytes into 32-bit words; pulses o_word_valid
// combinationally alongside the 4th byte so the caller can register the word.
module byte_word_asm
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [1:0]  r_cnt;
  // Only three bytes need storing; the 4th comes straight from i_byte.
  logic [23:0] r_shift;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (i_valid) begin
      r_cnt   <= r_cnt + 2'd1;
      r_shift <= {i_byte, r_shift[23:8]};
    end
  end

  assign o_word_valid = i_valid && (r_cnt == 2'(WORD_BYTES - 1));
  assign o_word       = {i_byte, r_shift};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length header + little-endian words into imem, core held in
// reset until the image is written. IMEM_LOADER_CSUM_EN adds an XOR check byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus,
  output logic         core_reset_n,
  output logic         done,
  output logic         error
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

  loader_state_t     r_state, w_next;
  logic              w_ready;
  logic              w_accept;
  logic [15:0]       r_len;
  logic [15:0]       w_len_full;
  logic              w_len_bad;
  logic [ADDR_W:0]   r_index;
  logic              w_last_word;
  logic              w_asm_valid;
  logic              w_asm_clear;
  logic              w_word_valid;
  logic [31:0]       w_word;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]        r_csum;
`endif

  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      S_LEN_LO, S_LEN_HI, S_DATA: w_ready = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
      S_CSUM:                     w_ready = 1'b1;
`endif
      default:                    w_ready = 1'b0;
    endcase
  end

  assign bus.rx_ready = w_ready && !reset;
  assign w_accept     = bus.rx_valid && bus.rx_ready;
  assign w_len_full   = {bus.rx_data, r_len[7:0]};
  assign w_len_bad    = (w_len_full == '0) || (32'(w_len_full) > DEPTH);
  assign w_last_word  = (32'(r_index) + 32'd1) == 32'(r_len);
  assign w_asm_valid  = w_accept && (r_state == S_DATA);
  assign w_asm_clear  = w_accept && (r_state == S_LEN_HI);

  byte_word_asm u_asm (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_asm_clear),
    .i_valid      (w_asm_valid),
    .i_byte       (bus.rx_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_LEN_LO;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LEN_LO: if (w_accept) w_next = S_LEN_HI;
      S_LEN_HI: if (w_accept) w_next = w_len_bad ? S_ERROR : S_DATA;
      S_DATA:   if (w_word_valid && w_last_word) w_next = S_FLUSH;
`ifdef IMEM_LOADER_CSUM_EN
      S_FLUSH:  w_next = S_CSUM;
      S_CSUM:   if (w_accept) w_next = (bus.rx_data == r_csum) ? S_RUN : S_ERROR;
`else
      S_FLUSH:  w_next = S_RUN;
`endif
      default:  w_next = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_len   <= '0;
      r_index <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      r_we <= w_word_valid;
      if (w_accept && r_state == S_LEN_LO) r_len[7:0] <= bus.rx_data;
      if (w_asm_clear) begin
        r_len[15:8] <= bus.rx_data;
        r_index     <= '0;
`ifdef IMEM_LOADER_CSUM_EN
        r_csum      <= '0;
`endif
      end
      if (w_word_valid) begin
        r_addr  <= r_index[ADDR_W-1:0];
        r_wdata <= w_word;
        r_index <= r_index + IDX_ONE;
      end
`ifdef IMEM_LOADER_CSUM_EN
      if (w_asm_valid) r_csum <= r_csum ^ bus.rx_data;
`endif
    end
  end

  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign done           = (r_state == S_RUN);
  assign core_reset_n   = (r_state == S_RUN);
  assign error          = (r_state == S_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus
// and popped by a monitor on every imem_we pulse.
module tb_imem_loader;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  logic core_reset_n, done, error;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .core_reset_n (core_reset_n),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  wr_t exp_q[$];
  wr_t mon_e;
  int  vectors     = 0;
  int  miscompares = 0;
  int  we_pulses   = 0;

  logic [7:0] stream [10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00,
                              8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
  int unsigned gaps  [10] = '{1, 0, 3, 2, 0, 1, 4, 0, 2, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && bus.imem_we === 1'b1) begin
      we_pulses++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.imem_addr !== mon_e.addr || bus.imem_wdata !== mon_e.data) begin
          miscompares++;
          $display("FAIL write: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                   bus.imem_addr, bus.imem_wdata, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input int unsigned gap);
    int unsigned n = 0;
    if (gap != 0) begin
      bus.rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (bus.rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.rx_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: rx_ready %0b, expected 1", bus.rx_ready);
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check({tag, "_rst_ready"}, 32'(bus.rx_ready), 32'd0);
    check({tag, "_rst_we"},    32'(bus.imem_we),  32'd0);
    check({tag, "_rst_addr"},  32'(bus.imem_addr), 32'd0);
    check({tag, "_rst_wdata"}, bus.imem_wdata,    32'd0);
    check({tag, "_rst_crn"},   32'(core_reset_n), 32'd0);
    check({tag, "_rst_done"},  32'(done),         32'd0);
    check({tag, "_rst_err"},   32'(error),        32'd0);
    reset = 1'b0;
    #1;
    check({tag, "_post_rst_ready"}, 32'(bus.rx_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic push_two();
    exp_q.push_back('{addr: 10'd0, data: 32'h0000_0013});
    exp_q.push_back('{addr: 10'd1, data: 32'h0010_0093});
  endtask

  task automatic run_stream(input bit use_gaps);
    for (int i = 0; i < 10; i++) send(stream[i], use_gaps ? gaps[i] : 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    logic [31:0] w;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    reset        = 1'b1;

    // Back-to-back stream and release timing
    do_reset("t1");
    push_two();
    run_stream(1'b0);
`ifdef IMEM_LOADER_CSUM_EN
    send(8'h90, 0);
    check("t1_done", 32'(done), 32'd1);
`else
    check("t1_flush_done", 32'(done), 32'd0);
    check("t1_flush_crn",  32'(core_reset_n), 32'd0);
    bus.rx_data = 8'hAA;
    @(negedge clk);
    check("t1_done", 32'(done), 32'd1);
    check("t1_crn",  32'(core_reset_n), 32'd1);
`endif
    check("t1_run_ready", 32'(bus.rx_ready), 32'd0);
    check("t1_err", 32'(error), 32'd0);
    repeat (4) @(negedge clk);
    bus.rx_valid = 1'b0;
    check("t1_queue", 32'(exp_q.size()), 32'd0);

    // Stream with rx_valid gaps
    do_reset("t2");
    base = we_pulses;
    push_two();
    run_stream(1'b1);
`ifdef IMEM_LOADER_CSUM_EN
    send(8'h90, 2);
`endif
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t2_done", 32'(done), 32'd1);
    check("t2_we_pulses", 32'(we_pulses - base), 32'd2);

    // Zero-length header
    do_reset("t3");
    send(8'h00, 0);
    send(8'h00, 0);
    check("t3_err",   32'(error), 32'd1);
    check("t3_ready", 32'(bus.rx_ready), 32'd0);
    check("t3_crn",   32'(core_reset_n), 32'd0);
    repeat (3) @(negedge clk);
    bus.rx_valid = 1'b0;
    check("t3_err_sticky", 32'(error), 32'd1);

    // N = DEPTH+1
    do_reset("t4");
    send(8'h01, 0);
    send(8'h04, 0);
    bus.rx_valid = 1'b0;
    check("t4_err",   32'(error), 32'd1);
    check("t4_ready", 32'(bus.rx_ready), 32'd0);
    check("t4_done",  32'(done), 32'd0);

    // N = DEPTH fills memory without index wrap
    do_reset("t5");
    send(8'h00, 0);
    send(8'h04, 0);
    for (int i = 0; i < int'(DEPTH); i++) begin
      w = 32'h1000_0000 + 32'(i) * 32'd7;
      exp_q.push_back('{addr: 10'(i), data: w});
      for (int b = 0; b < 4; b++) send(w[8*b +: 8], 0);
    end
`ifdef IMEM_LOADER_CSUM_EN
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_csum_wait_done", 32'(done), 32'd0);
`else
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_done", 32'(done), 32'd1);
`endif
    check("t5_err", 32'(error), 32'd0);
    check("t5_queue", 32'(exp_q.size()), 32'd0);

    // Reset mid-load after 5 bytes, then full resend
    do_reset("t6");
    for (int i = 0; i < 5; i++) send(stream[i], 0);
    do_reset("t6b");
    push_two();
    run_stream(1'b0);
`ifdef IMEM_LOADER_CSUM_EN
    send(8'h90, 0);
`endif
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_done", 32'(done), 32'd1);
    check("t6_queue", 32'(exp_q.size()), 32'd0);

`ifdef IMEM_LOADER_CSUM_EN
    // Checksum mismatch
    do_reset("t7");
    push_two();
    run_stream(1'b0);
    send(8'h91, 0);
    bus.rx_valid = 1'b0;
    check("t7_err",  32'(error), 32'd1);
    check("t7_crn",  32'(core_reset_n), 32'd0);
    check("t7_done", 32'(done), 32'd0);
`endif

    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
